// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among NUM_REQ valid/ready requesters.
// Operands and results are registered; responses carry the owning requester's ID.

module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        cout
);
    assign {cout, y} = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_y,
    output logic                  rsp_cout,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);
    localparam int unsigned NREQ = NUM_REQ;

    typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] ptr, id_q, winner, cand;
    logic            any_req;
    logic [31:0]     op_a, op_b, sum_y;
    logic            sum_cout;
    int unsigned     idx;

    adder u_adder (
        .a    (op_a),
        .b    (op_b),
        .y    (sum_y),
        .cout (sum_cout)
    );

    // Rotating priority: first asserted request at or after ptr, wrapping.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = ID_W'(idx);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready[winner] = 1'b1;
                    state_nx          = ADD;
                end
            end
            ADD:     state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            id_q     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            rsp_y    <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
            op_count <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a <= req_a[32*winner +: 32];
                        op_b <= req_b[32*winner +: 32];
                        id_q <= winner;
                    end
                end
                ADD: begin
                    rsp_y    <= sum_y;
                    rsp_cout <= sum_cout;
                    rsp_id   <= id_q;
                    ptr      <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                end
                RESP: begin
                    if (rsp_ready) op_count <= op_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vector table, corner sequences and random traffic
// checked every cycle against a transaction-timing reference model.

module tb_adder_arbiter;
    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*32-1:0]     req_a, req_b;
    logic                rsp_valid, rsp_ready;
    logic [31:0]         rsp_y;
    logic                rsp_cout;
    logic [ID_W-1:0]     rsp_id;
    logic                busy;
    logic [CNT_W-1:0]    op_count;

    adder_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] tb_a [N];
    logic [31:0] tb_b [N];

    // Sampled DUT outputs (mid-cycle)
    logic [N-1:0]     s_ready;
    logic             s_rv, s_cout, s_busy;
    logic [31:0]      s_y;
    logic [ID_W-1:0]  s_id;
    logic [CNT_W-1:0] s_cnt;

    // Reference model: one operation in flight, described by its grant cycle
    int          cyc;
    int          m_ptr, m_gcyc, m_id, m_cnt;
    bit          m_active;
    logic [32:0] m_sum;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        cout;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_gcyc = 0; m_id = 0; m_cnt = 0; m_active = 0; m_sum = '0; cyc = 0;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle: drive at posedge+1, sample and compare at negedge, advance model.
    task automatic step(input logic [N-1:0] v, input logic rr);
        int win;
        logic [N-1:0] e_ready;
        logic e_rv;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = tb_a[i];
            req_b[32*i +: 32] = tb_b[i];
        end
        @(negedge clk);
        s_ready = req_ready; s_rv = rsp_valid; s_y = rsp_y; s_cout = rsp_cout;
        s_id = rsp_id; s_busy = busy; s_cnt = op_count;
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        e_ready = '0;
        if (!m_active && win >= 0) e_ready[win] = 1'b1;
        e_rv = m_active && (cyc - m_gcyc >= 2);
        chk("model_req_ready", 64'(s_ready), 64'(e_ready));
        chk("model_rsp_valid", 64'(s_rv), 64'(e_rv));
        chk("model_busy", 64'(s_busy), 64'(m_active));
        chk("model_op_count", 64'(s_cnt), 64'(m_cnt));
        if (e_rv) begin
            chk("model_rsp_y", 64'(s_y), 64'(m_sum[31:0]));
            chk("model_rsp_cout", 64'(s_cout), 64'(m_sum[32]));
            chk("model_rsp_id", 64'(s_id), 64'(m_id));
        end
        if (e_rv && rr) begin
            m_active = 0;
            m_cnt    = (m_cnt + 1) % (1 << CNT_W);
        end else if (!m_active && win >= 0) begin
            m_active = 1;
            m_gcyc   = cyc;
            m_id     = win;
            m_sum    = {1'b0, tb_a[win]} + {1'b0, tb_b[win]};
            m_ptr    = (win + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_y", 64'(rsp_y), 64'(0));
        chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_op_count", 64'(op_count), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ey, input logic ec);
        logic [N-1:0] one;
        one = 1;
        tb_a[id] = a;
        tb_b[id] = b;
        step(one << id, 1'b0);
        chk("grant_same_cycle", 64'(s_ready), 64'(one << id));
        step('0, 1'b0);
        chk("no_rsp_in_add", 64'(s_rv), 64'(0));
        step('0, 1'b1);
        chk("rsp_valid_t2", 64'(s_rv), 64'(1));
        chk("rsp_y", 64'(s_y), 64'(ey));
        chk("rsp_cout", 64'(s_cout), 64'(ec));
        chk("rsp_id", 64'(s_id), 64'(id));
        step('0, 1'b0);
        chk("idle_after_rsp", 64'(s_busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1);
    end

    initial begin
        int got;
        int ids [8];
        int when [8];
        int exp_rr [8];
        logic [31:0] y0;
        logic c0;
        logic [ID_W-1:0] id0;
        logic [CNT_W-1:0] cnt0, cnt1;
        logic [N-1:0] cv;
        logic [32:0] s;

        tbl[0] = '{0, 32'd1,          32'd2,          32'd3,          1'b0};
        tbl[1] = '{2, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        tbl[2] = '{2, 32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1};
        tbl[3] = '{2, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0};
        exp_rr = '{0, 1, 2, 3, 0, 1, 3, 1};

        for (int i = 0; i < N; i++) begin tb_a[i] = '0; tb_b[i] = '0; end
        req_a = '0; req_b = '0;
        model_reset();
        do_reset();

        // Single op and carry cases
        for (int t = 0; t < 4; t++) begin
            run_op(tbl[t].id, tbl[t].a, tbl[t].b, tbl[t].y, tbl[t].cout);
            if (t == 0) chk("op_count_after_first", 64'(s_cnt), 64'(1));
        end

        // Round-robin ordering and spacing
        do_reset();
        for (int i = 0; i < N; i++) begin tb_a[i] = 32'(100 * i); tb_b[i] = 32'(i); end
        got = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            step(got < 5 ? 4'b1111 : 4'b1010, 1'b1);
            if (s_rv) begin
                ids[got]  = int'(s_id);
                when[got] = cyc;
                got++;
            end
        end
        chk("rr_response_count", 64'(got), 64'(8));
        for (int i = 0; i < got; i++) chk("rr_order", 64'(ids[i]), 64'(exp_rr[i]));
        for (int i = 1; i < 5 && i < got; i++) chk("rr_spacing", 64'(when[i] - when[i-1]), 64'(3));

        // Backpressure while other requesters wait
        tb_a[1] = 32'hDEAD_BEEF; tb_b[1] = 32'h3000_0000;
        step(4'b0010, 1'b0);
        chk("bp_grant", 64'(s_ready), 64'(4'b0010));
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        y0 = s_y; c0 = s_cout; id0 = s_id; cnt0 = s_cnt;
        for (int i = 0; i < 5; i++) begin
            step(4'b0101, 1'b0);
            chk("bp_rsp_valid", 64'(s_rv), 64'(1));
            chk("bp_rsp_y_held", 64'(s_y), 64'(y0));
            chk("bp_rsp_cout_held", 64'(s_cout), 64'(c0));
            chk("bp_rsp_id_held", 64'(s_id), 64'(id0));
            chk("bp_req_ready_low", 64'(s_ready), 64'(0));
            chk("bp_op_count_held", 64'(s_cnt), 64'(cnt0));
        end
        chk("bp_rsp_y_value", 64'(y0), 64'(32'h0EAD_BEEF));
        chk("bp_rsp_cout_value", 64'(c0), 64'(1));
        step(4'b0101, 1'b1);
        step('0, 1'b0);
        cnt1 = cnt0 + 1'b1;
        chk("bp_idle_after", 64'(s_busy), 64'(0));
        chk("bp_op_count_inc", 64'(s_cnt), 64'(cnt1));

        // Reset while requester 3 is in ADD
        tb_a[3] = 32'h1234_5678; tb_b[3] = 32'h1111_1111;
        step(4'b1000, 1'b0);
        chk("radd_grant", 64'(s_ready), 64'(4'b1000));
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("radd_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("radd_busy", 64'(busy), 64'(0));
        chk("radd_op_count", 64'(op_count), 64'(0));
        chk("radd_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) step('0, 1'b1);
        tb_a[0] = 32'd7; tb_b[0] = 32'd8;
        step(4'b1001, 1'b1);
        chk("radd_ptr_zero", 64'(s_ready), 64'(4'b0001));
        step('0, 1'b0);
        step('0, 1'b1);
        chk("radd_rsp_y", 64'(s_y), 64'(15));
        step('0, 1'b0);

        // Counter wrap at 2^CNT_W
        do_reset();
        for (int t = 0; t < 5; t++) begin
            logic [31:0] ra, rb;
            ra = rnd(); rb = rnd();
            s  = {1'b0, ra} + {1'b0, rb};
            run_op(t % N, ra, rb, s[31:0], s[32]);
        end
        chk("op_count_wrap", 64'(s_cnt), 64'(1));

        // Random traffic against the model
        cv = '0;
        for (int c = 0; c < 400; c++) begin
            step(cv, 1'($urandom_range(0, 3) != 0));
            for (int i = 0; i < N; i++) begin
                if (s_ready[i]) begin
                    cv[i] = 1'($urandom_range(0, 1));
                    tb_a[i] = rnd(); tb_b[i] = rnd();
                end else if (!cv[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        cv[i] = 1'b1;
                        tb_a[i] = rnd(); tb_b[i] = rnd();
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    cv[i] = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit `adder` instance (ports a, b, y, cout) among NUM_REQ independent requesters.
- Each requester has a valid/ready request channel; arbitration is round-robin.
- Operands are registered before they drive the adder. The sum and carry-out are registered and returned on a single valid/ready response channel tagged with the requester ID.
- The block sits between client logic and the shared adder datapath; it is the only driver of the adder inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the requester ID tag.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept; at most one bit high.
- req_a  input  NUM_REQ*32  flattened operand A; requester i uses bits [32*i+31:32*i].
- req_b  input  NUM_REQ*32  flattened operand B; same packing as req_a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted by the consumer.
- rsp_y  output  32  registered sum (a+b) mod 2^32.
- rsp_cout  output  1  registered carry-out of the 32-bit add.
- rsp_id  output  ID_W  index of the requester that owns the response.
- busy  output  1  high whenever the state is not IDLE.
- op_count  output  CNT_W  number of completed response handshakes, wrapping.

Behaviour:
- Reset: state=IDLE, round-robin pointer ptr=0. All outputs are 0: req_ready, rsp_valid, rsp_y, rsp_cout, rsp_id, busy, op_count. The operand registers are also cleared.
- FSM states: IDLE, ADD, RESP.
- IDLE, arbitration:
  - If any req_valid bit is set, the winner is the first set bit searching ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - req_ready[winner] is asserted combinationally in the same cycle; this is the request handshake.
  - On that edge: operand registers <= the winner's a/b, id register <= winner, state -> ADD.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- ADD:
  - The registered operands drive the adder.
  - On the edge: rsp_y <= y, rsp_cout <= cout, rsp_id <= id register, state -> RESP, ptr <= (winner+1) mod NUM_REQ.
- RESP:
  - rsp_valid=1.
  - rsp_y, rsp_cout and rsp_id are held stable until rsp_ready=1.
  - On the handshake edge: state -> IDLE, op_count <= op_count+1 (wraps to 0 at 2^CNT_W).
- req_ready is 0 in ADD and RESP; it is never asserted for more than one requester.
- Latency: a request handshake at cycle T gives rsp_valid=1 at T+2.
- Throughput: minimum 3 cycles per operation (IDLE, ADD, RESP). A new request is never accepted in the same cycle as a response handshake.
- Requester rules:
  - Must hold req_valid and its operands stable until req_ready.
  - May drop req_valid before it is granted; arbitration is re-evaluated every IDLE cycle using the current inputs.
- Arithmetic: unsigned 32-bit add; cout is bit 32 of the true sum. There is no carry-in.
- rsp_ready while rsp_valid=0 is ignored.
- A requester that is not currently asserting req_valid does not hold or block ptr.
- Reset mid-operation (ADD or RESP):
  - The operation is discarded with no response.
  - All state and outputs return to reset values immediately, asynchronously.
  - ptr returns to 0.

Test Plan:
1. Single op: after reset, req_valid=0001, a0=1, b0=2.
   - Required: req_ready=0001 in the same cycle.
   - Two cycles later: rsp_valid=1, rsp_y=3, rsp_cout=0, rsp_id=0.
   - After the rsp_ready handshake: op_count=1, busy=0.
2. Carry: requester 2 with a=0xFFFFFFFF, b=1 -> rsp_y=0, rsp_cout=1, rsp_id=2. Then a=0x80000000, b=0x80000000 -> rsp_y=0, rsp_cout=1. Then a=0x7FFFFFFF, b=1 -> rsp_y=0x80000000, rsp_cout=0.
3. Round-robin: req_valid=1111 held continuously with rsp_ready=1.
   - Required: responses rsp_id=0,1,2,3,0, spaced 3 cycles apart.
   - Then req_valid=1010 from ptr=1: order 1,3,1.
4. Backpressure: rsp_ready=0 for 5 cycles during RESP.
   - Required: rsp_valid stays 1, rsp_y/rsp_cout/rsp_id are unchanged, req_ready=0 throughout, op_count is unchanged.
   - After releasing rsp_ready: IDLE on the next cycle, op_count increments by 1.
5. Reset in ADD: assert rst while in ADD with requester 3 granted.
   - Required: rsp_valid, busy and op_count are 0 immediately; no response ever appears.
   - After deassert with req_valid=1001: requester 0 wins (ptr=0).
6. Counter wrap with CNT_W=2: complete 5 operations -> op_count=1.
